// File: rtl/game_menu_screen.sv
// Purpose: vertical NUM_ITEMS-row menu renderer with wrapping cursor, blinking chevrons and a confirm handshake.
// Latency: oled_data is registered, one cycle after (x, y, text_px); sel_index/sel_valid update on the sampling edge.
// Backpressure: a confirmed selection is held on sel_valid until sel_ready; cursor moves are ignored meanwhile.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   frame_tick            - one pulse per OLED frame, drives the blink timer
//   btn_up/btn_down/btn_sel - debounced single-cycle button pulses
//   x, y, text_px         - pixel coordinate from the index decoder and glyph bit from the text ROM
//   oled_data             - registered RGB565 pixel to the OLED driver
//   sel_index             - current cursor row
//   sel_valid, sel_ready  - confirmed-selection handshake towards the game FSM
module game_menu_screen #(
  parameter int          NUM_ITEMS    = 4,
  parameter int          ITEM_X0      = 18,
  parameter int          ITEM_X1      = 81,
  parameter int          ITEM_Y0      = 20,
  parameter int          ITEM_H       = 7,
  parameter int          ITEM_PITCH   = 10,
  parameter int          BLINK_FRAMES = 15,
  parameter logic [15:0] FG           = 16'h0000,
  parameter logic [15:0] BG           = 16'hFFFF,
  parameter logic [15:0] HL           = 16'h5FFF,
  parameter logic [15:0] CUR          = 16'hF800,
  localparam int         IDX_W        = $clog2(NUM_ITEMS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  input  logic [6:0]       x,
  input  logic [5:0]       y,
  input  logic             text_px,
  output logic [15:0]      oled_data,
  output logic [IDX_W-1:0] sel_index,
  output logic             sel_valid,
  input  logic             sel_ready
);

  // Blink frame counter width; a single-frame phase still needs one bit.
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0]   FCNT_LAST = FCW'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ITEMS - 1);

  // All geometry is compared at 8 bits unsigned so off-screen coordinates
  // (x up to 127) can never wrap into a band.
  localparam logic [7:0] X0_8    = 8'(ITEM_X0);
  localparam logic [7:0] X1_8    = 8'(ITEM_X1);
  localparam logic [7:0] Y0_8    = 8'(ITEM_Y0);
  localparam logic [7:0] PITCH_8 = 8'(ITEM_PITCH);
  localparam logic [7:0] HALF_8  = 8'(ITEM_H / 2);
  localparam logic [7:0] LX_OUT  = 8'(ITEM_X0 - 4);
  localparam logic [7:0] LX_IN   = 8'(ITEM_X0 - 3);
  localparam logic [7:0] RX_OUT  = 8'(ITEM_X1 + 4);
  localparam logic [7:0] RX_IN   = 8'(ITEM_X1 + 3);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] sel_index_q;
  logic             sel_valid_q;
  logic [FCW-1:0]   fcnt_q;
  logic             blink_q;
  logic [15:0]      oled_q;

  // ------------------------------------------------------------------
  // Cursor move candidates (wrapping at both ends)
  // ------------------------------------------------------------------
  logic [IDX_W-1:0] idx_up_d;
  logic [IDX_W-1:0] idx_dn_d;

  always_comb begin
    idx_up_d = (sel_index_q == '0)       ? IDX_LAST : sel_index_q - IDX_W'(1);
    idx_dn_d = (sel_index_q == IDX_LAST) ? '0       : sel_index_q + IDX_W'(1);
  end

  // ------------------------------------------------------------------
  // Pixel shading
  // ------------------------------------------------------------------
  logic [7:0]  x8;
  logic [7:0]  y8;
  logic        on_screen;
  logic        in_any;
  logic        in_sel;
  logic [7:0]  sel_top;
  logic [7:0]  yc;
  logic        cur_px;
  logic        cur_vis;
  logic [15:0] pix_d;

  always_comb begin
    logic [7:0] top;
    logic [7:0] bot;
    logic       hit;

    x8        = {1'b0, x};
    y8        = {2'b0, y};
    on_screen = (x8 < 8'd96) && (y8 < 8'd64);

    in_any = 1'b0;
    in_sel = 1'b0;
    top    = '0;
    bot    = '0;
    hit    = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      top = 8'(ITEM_Y0 + i * ITEM_PITCH);
      bot = 8'(ITEM_Y0 + i * ITEM_PITCH + ITEM_H - 1);
      // Band rows past the bottom of the panel fall out via on_screen.
      hit = on_screen && (x8 >= X0_8) && (x8 <= X1_8) && (y8 >= top) && (y8 <= bot);
      in_any = in_any | hit;
      if (IDX_W'(i) == sel_index_q) begin
        in_sel = hit;
      end
    end

    // Centre row of the selected band carries the chevron tips.
    sel_top = Y0_8 + 8'(sel_index_q) * PITCH_8;
    yc      = sel_top + HALF_8;

    cur_px = on_screen &&
             ((((x8 == LX_OUT) || (x8 == RX_OUT)) && ((y8 == yc - 8'd1) || (y8 == yc + 8'd1))) ||
              (((x8 == LX_IN)  || (x8 == RX_IN))  &&  (y8 == yc)));

    // A pending selection shows a solid cursor regardless of blink phase.
    cur_vis = blink_q || (state_q == S_PEND);

    if (in_any && text_px) begin
      pix_d = FG;
    end else if (cur_vis && cur_px) begin
      pix_d = CUR;
    end else if (in_sel) begin
      pix_d = HL;
    end else begin
      pix_d = BG;
    end
  end

  // ------------------------------------------------------------------
  // Menu FSM, blink timer and output register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_index_q <= '0;
      sel_valid_q <= 1'b0;
      fcnt_q      <= '0;
      blink_q     <= 1'b1;
      oled_q      <= 16'h0000;
    end else begin
      // The frame timer runs in both states so the blink phase stays
      // locked to the frame rate across a confirm.
      if (frame_tick) begin
        if (fcnt_q == FCNT_LAST) begin
          fcnt_q  <= '0;
          blink_q <= ~blink_q;
        end else begin
          fcnt_q  <= fcnt_q + FCW'(1);
        end
      end

      if (state_q == S_IDLE) begin
        if (btn_sel) begin
          // Confirm wins over a same-cycle move; the later blink_q write
          // also overrides any toggle from the frame timer this cycle.
          state_q     <= S_PEND;
          sel_valid_q <= 1'b1;
          blink_q     <= 1'b1;
        end else if (btn_up && !btn_down) begin
          sel_index_q <= idx_up_d;
        end else if (btn_down && !btn_up) begin
          sel_index_q <= idx_dn_d;
        end
      end else begin
        if (sel_ready) begin
          state_q     <= S_IDLE;
          sel_valid_q <= 1'b0;
        end
      end

      oled_q <= pix_d;
    end
  end

  assign oled_data = oled_q;
  assign sel_index = sel_index_q;
  assign sel_valid = sel_valid_q;

endmodule

// File: tb/tb_game_menu_screen.sv
// Directed bench for game_menu_screen with default parameters.
// Geometry: bands at y 20/30/40/50 (+6), x 18..81; centre rows 23/33/43/53;
// left chevron x=14 (yc+-1), x=15 (yc); right chevron x=85 (yc+-1), x=84 (yc).
module tb_game_menu_screen;

  localparam logic [15:0] C_FG  = 16'h0000;
  localparam logic [15:0] C_BG  = 16'hFFFF;
  localparam logic [15:0] C_HL  = 16'h5FFF;
  localparam logic [15:0] C_CUR = 16'hF800;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        btn_up;
  logic        btn_down;
  logic        btn_sel;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        text_px;
  logic [15:0] oled_data;
  logic [1:0]  sel_index;
  logic        sel_valid;
  logic        sel_ready;

  int n_vec;
  int n_err;

  game_menu_screen dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_sel    (btn_sel),
    .x          (x),
    .y          (y),
    .text_px    (text_px),
    .oled_data  (oled_data),
    .sel_index  (sel_index),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then stable 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int px, input int py, input logic t, input string tag,
                       input logic [15:0] exp);
    x       = 7'(px);
    y       = 6'(py);
    text_px = t;
    tick();
    check_eq(tag, oled_data, exp);
  endtask

  task automatic press(input logic u, input logic d, input logic s);
    btn_up   = u;
    btn_down = d;
    btn_sel  = s;
    tick();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_sel  = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    frame_tick = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    btn_sel    = 1'b0;
    sel_ready  = 1'b0;
    x          = '0;
    y          = '0;
    text_px    = 1'b0;

    // Reset state
    #2;
    check_eq("rst_oled",  oled_data, 16'h0000);
    check_eq("rst_index", 16'(sel_index), 16'd0);
    check_eq("rst_valid", 16'(sel_valid), 16'd0);
    tick();
    reset = 1'b0;
    tick();

    // Item 0 selected, blink on
    pixel(15, 23, 1'b0, "chev_left_tip0", C_CUR);
    pixel(85, 24, 1'b0, "chev_right_low0", C_CUR);
    pixel(40, 21, 1'b0, "hl_item0", C_HL);
    pixel(18, 26, 1'b0, "hl_corner0", C_HL);
    pixel(18, 27, 1'b0, "below_band0", C_BG);
    pixel(82, 20, 1'b0, "right_of_band0", C_BG);
    pixel(40, 31, 1'b0, "unsel_item1", C_BG);

    // Cursor moves with wrap
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0);
    check_eq("down5_wrap", 16'(sel_index), 16'd1);
    press(1'b1, 1'b0, 1'b0);
    check_eq("up_to0", 16'(sel_index), 16'd0);
    press(1'b1, 1'b0, 1'b0);
    check_eq("up_wrap3", 16'(sel_index), 16'd3);
    press(1'b1, 1'b1, 1'b0);
    check_eq("up_down_hold", 16'(sel_index), 16'd3);
    sel_ready = 1'b1;
    tick();
    sel_ready = 1'b0;
    check_eq("ready_idle", 16'(sel_valid), 16'd0);
    pixel(40, 51, 1'b0, "hl_item3", C_HL);
    pixel(40, 21, 1'b0, "old_hl_gone", C_BG);

    // Blink phase
    frames(15);
    pixel(15, 53, 1'b0, "blink_off_l", C_BG);
    pixel(84, 53, 1'b0, "blink_off_r", C_BG);
    frames(15);
    pixel(15, 53, 1'b0, "blink_on_again", C_CUR);

    // Confirm with simultaneous move, then locked moves
    press(1'b1, 1'b0, 1'b0);
    check_eq("up_to2", 16'(sel_index), 16'd2);
    press(1'b0, 1'b1, 1'b1);
    check_eq("sel_valid_up", 16'(sel_valid), 16'd1);
    check_eq("sel_index_frozen", 16'(sel_index), 16'd2);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0);
    check_eq("pend_no_move", 16'(sel_index), 16'd2);

    // Blink wrap while pending keeps chevron solid
    frames(15);
    pixel(15, 43, 1'b0, "pend_solid", C_CUR);

    for (int i = 0; i < 10; i++) tick();
    check_eq("valid_held", 16'(sel_valid), 16'd1);
    sel_ready = 1'b1;
    tick();
    sel_ready = 1'b0;
    check_eq("valid_fall", 16'(sel_valid), 16'd0);
    // Blink phase is off after the wrap, now visible again in IDLE
    pixel(15, 43, 1'b0, "idle_blink_off", C_BG);
    pixel(40, 43, 1'b0, "hl_item2", C_HL);

    // Reset during a pending selection
    press(1'b0, 1'b0, 1'b1);
    check_eq("valid_again", 16'(sel_valid), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", 16'(sel_valid), 16'd0);
    check_eq("arst_index", 16'(sel_index), 16'd0);
    check_eq("arst_oled",  oled_data, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    pixel(15, 23, 1'b0, "post_rst_chev", C_CUR);

    // Off-screen and text priority
    pixel(100, 63, 1'b1, "offscreen_bg", C_BG);
    pixel(50, 20, 1'b1, "text_fg", C_FG);
    pixel(50, 30, 1'b1, "text_unsel_fg", C_FG);
    pixel(10, 30, 1'b1, "text_outside_bg", C_BG);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
